// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner/state encodings and default timing constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of cycles the fetch port waited without a grant
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam int W = $clog2(STARVE_MAX + 1);
  logic [W-1:0] cnt;
  // Clear wins over increment; the count sticks at the ceiling once reached
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  // Saturation is what hands priority to the fetch port
  always_comb sat = cnt == W'(STARVE_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory between fetch and data ports; MEM_ARB_PERF_COUNTERS_EN adds grant/conflict counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_conflicts
`endif
);
  localparam int LW = 2;
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic wait_busy, respond, grantable, fetch_win, rd_gnt, starve_sat;
  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (if_gnt),
    .inc  (if_req && !if_gnt),
    .sat  (starve_sat)
  );
  // Same-cycle arbitration; grants are gated by rst_n so every output is quiet while in reset
  always_comb begin
    wait_busy = state_q == ST_WAIT && cnt_q != '0;
    respond = state_q == ST_WAIT && cnt_q == '0;
    grantable = rst_n && !wait_busy;
    fetch_win = if_req && (!d_req || starve_sat);
    if_gnt = grantable && fetch_win;
    d_gnt = grantable && d_req && !fetch_win;
    rd_gnt = if_gnt || (d_gnt && !d_we);
    mem_en = if_gnt || d_gnt;
    mem_we = d_gnt && d_we;
    mem_addr = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    if_rvalid = respond && owner_q == OWN_FETCH;
    d_rvalid = respond && owner_q == OWN_DATA;
    if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata = d_rvalid ? mem_rdata : d_rdata_q;
  end
  // Next state: count down while a read is outstanding, reload on each new read grant
  always_comb begin
    state_d = (wait_busy || rd_gnt) ? ST_WAIT : ST_IDLE;
    cnt_d = wait_busy ? cnt_q - 1'b1 : rd_gnt ? LW'(LATENCY - 1) : '0;
    owner_d = rd_gnt ? (if_gnt ? OWN_FETCH : OWN_DATA) : owner_q;
  end
  // State register; reset abandons any read in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
    end
  // Each port's read data holds its last delivered value between responses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (d_rvalid) d_rdata_q <= mem_rdata;
    end
  // Grants only ever go to a requesting port, and never to both at once
  always_comb assert (!(if_gnt && !if_req) && !(d_gnt && !d_req) && !(if_gnt && d_gnt));
`ifdef MEM_ARB_PERF_COUNTERS_EN
  // Free-running, wrapping performance counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_if_grants <= '0;
      perf_d_grants <= '0;
      perf_conflicts <= '0;
    end else begin
      if (if_gnt) perf_if_grants <= perf_if_grants + 1'b1;
      if (d_gnt) perf_d_grants <= perf_d_grants + 1'b1;
      if (grantable && if_req && d_req) perf_conflicts <= perf_conflicts + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of two arbiters (LATENCY 1 and 3) against a transaction-level model
module tb_mem_port_arbiter;
  localparam int SMAX = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0] if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  mem_port_arbiter #(.LATENCY(1), .STARVE_MAX(SMAX)) u1 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]));
  mem_port_arbiter #(.LATENCY(3), .STARVE_MAX(SMAX)) u3 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]));
  // memory models: word-indexed by addr[9:2], read data appears LATENCY cycles after the strobe
  logic [31:0] mem [2][256];
  logic [31:0] pipe [2][4];
  logic env_ready = 1'b0;
  always @(posedge clk)
    if (!env_ready) begin
      for (int k = 0; k < 2; k++) for (int i = 0; i < 256; i++) mem[k][i] <= (i == 128) ? 32'hDEAD : 32'hA0 + 32'(4 * i);
      env_ready <= 1'b1;
    end else
      for (int k = 0; k < 2; k++) begin
        if (mem_en[k] && mem_we[k]) mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
        pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem[k][mem_addr[k][9:2]] : 32'hBAD0BAD0;
        for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
      end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];
  // reference model: per DUT, the cycle its outstanding read returns, who owns it and what it returns
  int cyc = 0, errs = 0, checks = 0;
  int due [2], starve [2];
  logic own [2], e_ig [2], e_dg [2];
  logic [31:0] rdat [2], held_if [2], held_d [2];
  logic [31:0] ref_mem [2][256];
  function automatic int lat(input int k);
    return k == 0 ? 1 : 3;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      due[k] = -1;
      starve[k] = 0;
      held_if[k] = '0;
      held_d[k] = '0;
    end
  endtask
  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ifg%0d", tag, k), if_gnt[k], 0);
      chk($sformatf("%s_dg%0d", tag, k), d_gnt[k], 0);
      chk($sformatf("%s_ifv%0d", tag, k), if_rvalid[k], 0);
      chk($sformatf("%s_dv%0d", tag, k), d_rvalid[k], 0);
      chk($sformatf("%s_ifd%0d", tag, k), if_rdata[k], 0);
      chk($sformatf("%s_dd%0d", tag, k), d_rdata[k], 0);
      chk($sformatf("%s_en%0d", tag, k), mem_en[k], 0);
      chk($sformatf("%s_we%0d", tag, k), mem_we[k], 0);
      chk($sformatf("%s_ad%0d", tag, k), mem_addr[k], 0);
      chk($sformatf("%s_wd%0d", tag, k), mem_wdata[k], 0);
    end
  endtask
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    #1;
  endtask
  // compare every output of both DUTs with the model, then advance one clock
  task automatic cycle();
    logic g, rsp, fw;
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      g = due[k] <= cyc;
      rsp = due[k] == cyc;
      fw = if_req && (!d_req || starve[k] == SMAX);
      e_ig[k] = g && fw;
      e_dg[k] = g && d_req && !fw;
      chk($sformatf("c%0d_if_gnt%0d", cyc, k), if_gnt[k], e_ig[k]);
      chk($sformatf("c%0d_d_gnt%0d", cyc, k), d_gnt[k], e_dg[k]);
      chk($sformatf("c%0d_mem_en%0d", cyc, k), mem_en[k], e_ig[k] || e_dg[k]);
      chk($sformatf("c%0d_mem_we%0d", cyc, k), mem_we[k], e_dg[k] && d_we);
      if (e_ig[k] || e_dg[k]) chk($sformatf("c%0d_mem_addr%0d", cyc, k), mem_addr[k], e_dg[k] ? d_addr : if_addr);
      if (e_dg[k] && d_we) chk($sformatf("c%0d_mem_wdata%0d", cyc, k), mem_wdata[k], d_wdata);
      chk($sformatf("c%0d_if_rvalid%0d", cyc, k), if_rvalid[k], rsp && !own[k]);
      chk($sformatf("c%0d_d_rvalid%0d", cyc, k), d_rvalid[k], rsp && own[k]);
      chk($sformatf("c%0d_if_rdata%0d", cyc, k), if_rdata[k], (rsp && !own[k]) ? rdat[k] : held_if[k]);
      chk($sformatf("c%0d_d_rdata%0d", cyc, k), d_rdata[k], (rsp && own[k]) ? rdat[k] : held_d[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (due[k] == cyc) begin
        if (own[k]) held_d[k] = rdat[k];
        else held_if[k] = rdat[k];
      end
      a = e_dg[k] ? d_addr : if_addr;
      if (e_ig[k] || (e_dg[k] && !d_we)) begin
        due[k] = cyc + lat(k);
        own[k] = e_dg[k];
        rdat[k] = ref_mem[k][a[9:2]];
      end
      if (e_dg[k] && d_we) ref_mem[k][a[9:2]] = d_wdata;
      starve[k] = e_ig[k] ? 0 : if_req ? (starve[k] < SMAX ? starve[k] + 1 : SMAX) : starve[k];
    end
    cyc++;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      drive(0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask
  initial begin
    logic [31:0] ra;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = 1'b0;
      rdat[k] = '0;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = (i == 128) ? 32'hDEAD : 32'hA0 + 32'(4 * i);
    end
    #1 chk_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // asynchronous reset with a fetch of 0x100 in flight
    drive(1, 32'h100, 0, 0, 0, 0);
    cycle();
    #1 rst_n = 1'b0; if_req = 1'b0;
    #1 chk_zero("rst_mid");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    idle(5);
    // back-to-back fetches at LATENCY 1
    drive(1, 32'h0, 0, 0, 0, 0);
    chk("t2_gnt0", if_gnt[0], 1);
    cycle();
    drive(1, 32'h4, 0, 0, 0, 0);
    chk("t2_gnt1", if_gnt[0], 1); chk("t2_rv0", if_rvalid[0], 1); chk("t2_rd0", if_rdata[0], 32'hA0);
    cycle();
    drive(1, 32'h8, 0, 0, 0, 0);
    chk("t2_gnt2", if_gnt[0], 1); chk("t2_rv1", if_rvalid[0], 1); chk("t2_rd1", if_rdata[0], 32'hA4);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_rv2", if_rvalid[0], 1); chk("t2_rd2", if_rdata[0], 32'hA8);
    cycle();
    idle(3);
    // contention: data first, fetch in the response cycle
    drive(1, 32'h10, 1, 0, 32'h200, 0);
    chk("t3_dg", d_gnt[0], 1); chk("t3_ifg0", if_gnt[0], 0);
    cycle();
    drive(1, 32'h10, 0, 0, 0, 0);
    chk("t3_dv", d_rvalid[0], 1); chk("t3_dd", d_rdata[0], 32'hDEAD); chk("t3_ifg1", if_gnt[0], 1);
    cycle();
    idle(3);
    // starvation: fetch wins on the fifth contended cycle, then the count restarts
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h20, 1, 0, 32'h40 + 32'(4 * i), 0);
      chk($sformatf("t4_ifg%0d", i), if_gnt[0], i == 4);
      chk($sformatf("t4_dg%0d", i), d_gnt[0], i != 4);
      cycle();
    end
    idle(4);
    // store then load back
    drive(0, 0, 1, 1, 32'h300, 32'h12345678);
    chk("t5_en", mem_en[0], 1); chk("t5_we", mem_we[0], 1);
    chk("t5_ad", mem_addr[0], 32'h300); chk("t5_wd", mem_wdata[0], 32'h12345678);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_nodv", d_rvalid[0], 0);
    cycle();
    drive(0, 0, 1, 0, 32'h300, 0);
    chk("t5_ldg", d_gnt[0], 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_dv", d_rvalid[0], 1); chk("t5_dd", d_rdata[0], 32'h12345678);
    cycle();
    idle(4);
    // LATENCY 3: no grants until the response cycle, where the pending load is taken
    drive(1, 32'h8, 0, 0, 0, 0);
    chk("t6_ifg", if_gnt[1], 1);
    cycle();
    for (int j = 1; j <= 3; j++) begin
      drive(0, 0, 1, 0, 32'h200, 0);
      chk($sformatf("t6_ifg%0d", j), if_gnt[1], 0);
      chk($sformatf("t6_dg%0d", j), d_gnt[1], j == 3);
      chk($sformatf("t6_rv%0d", j), if_rvalid[1], j == 3);
      if (j == 3) chk("t6_rd", if_rdata[1], 32'hA8);
      cycle();
    end
    idle(4);
    // top-of-address-space pass-through
    drive(1, 32'hFFFFFFFC, 0, 0, 0, 0);
    chk("wrap_ad", mem_addr[0], 32'hFFFFFFFC);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    chk("wrap_rd", if_rdata[0], 32'h49C);
    cycle();
    idle(3);
    // random traffic, including requests withdrawn before grant
    repeat (400) begin
      ra = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : 32'($urandom_range(0, 255)) << 2;
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ra, $urandom);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
